bram_row_streamer: RTL
======================

BRAM_ROW_STREAMER -- requirements
Module: bram_row_streamer

Interface
REQ-001 SHALL have parameter NUMBER_OF_COLUMNS, default 8, columns per BRAM row.
REQ-002 SHALL have parameter COLUMN_WIDTH, default 16, bits per column.
REQ-003 SHALL have parameter DEPTH, default 128, BRAM rows; localparams ADDR_WIDTH=$clog2(DEPTH), COL_IDX_WIDTH=max(1,$clog2(NUMBER_OF_COLUMNS)), DATA_WIDTH=NUMBER_OF_COLUMNS*COLUMN_WIDTH.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  request to begin a transfer; sampled only in IDLE.
REQ-007 SHALL have port base_addr  input  ADDR_WIDTH  first row to read; sampled with start.
REQ-008 SHALL have port num_rows  input  ADDR_WIDTH+1  rows to stream; sampled with start.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse at transfer completion.
REQ-011 SHALL have port enb  output  1  BRAM read-port enable.
REQ-012 SHALL have port addrb  output  ADDR_WIDTH  BRAM read address.
REQ-013 SHALL have port doutb  input  DATA_WIDTH  BRAM read data, valid one cycle after enb.
REQ-014 SHALL have port m_valid  output  1  column beat valid.
REQ-015 SHALL have port m_ready  input  1  downstream accepts beat.
REQ-016 SHALL have port m_data  output  COLUMN_WIDTH  column value.
REQ-017 SHALL have port m_col  output  COL_IDX_WIDTH  column index of current beat.
REQ-018 SHALL have port m_last  output  1  high on final beat of final row.

Function
REQ-019 SHALL implement states IDLE, READ, CAPTURE, STREAM, DONE.
REQ-020 IDLE: start=1 and num_rows>0 SHALL latch base_addr/num_rows, clear row counter, go to READ.
REQ-021 IDLE: start=1 and num_rows=0 SHALL go to DONE without asserting enb.
REQ-022 READ: SHALL assert enb=1 for exactly one cycle with addrb=(base_addr+row_count) mod 2**ADDR_WIDTH, then go to CAPTURE.
REQ-023 CAPTURE: SHALL load doutb into an internal row register, set column index 0, go to STREAM; enb=0.
REQ-024 STREAM: m_valid=1, m_data=row register column m_col (column 0 at bits [COLUMN_WIDTH-1:0]), m_col=current index.
REQ-025 Beat transfers only when m_valid&&m_ready; m_data, m_col, m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-026 On transfer with index<NUMBER_OF_COLUMNS-1, index SHALL increment by 1, state unchanged.
REQ-027 On transfer of index NUMBER_OF_COLUMNS-1: row_count+1<num_rows -> increment row_count, go to READ; else go to DONE.
REQ-028 m_last SHALL be 1 only when index=NUMBER_OF_COLUMNS-1 and row_count=num_rows-1.
REQ-029 DONE: done=1 for one cycle, then IDLE; busy=1 in DONE, 0 in IDLE.
REQ-030 start while busy=1 SHALL be ignored, no effect on latched values.
REQ-031 Row address SHALL wrap modulo 2**ADDR_WIDTH (e.g. base 126, DEPTH 128, 4 rows -> 126,127,0,1).
REQ-032 enb SHALL be 0 in every state except READ; addrb SHALL hold last driven value otherwise.
REQ-033 Per row, first beat SHALL appear 2 cycles after leaving STREAM/IDLE (READ+CAPTURE); with m_ready=1 a row occupies NUMBER_OF_COLUMNS+2 cycles.
REQ-034 m_valid SHALL be 0 in IDLE, READ, CAPTURE, DONE.

Reset
REQ-035 rst=1 SHALL asynchronously force IDLE and busy=0, done=0, enb=0, addrb=0, m_valid=0, m_data=0, m_col=0, m_last=0, row register=0, counters=0.
REQ-036 rst asserted mid-transfer SHALL abandon it: no done pulse, no further beats; after release the block waits for a new start.

Verification
REQ-037 Basic: base_addr=5, num_rows=2, m_ready=1, BRAM rows 5,6 preloaded -> enb at addrb 5 then 6, 16 beats m_col 0..7 twice, m_last on beat 16 only, done one cycle after last beat, total 20 cycles from start to done.
REQ-038 Backpressure: num_rows=1, m_ready toggled 1/0 randomly -> exactly 8 beats, m_data/m_col unchanged during stalls, order 0..7 preserved.
REQ-039 Wrap: base_addr=126, num_rows=4 -> addrb sequence 126,127,0,1 and data matches those rows.
REQ-040 Zero length: start with num_rows=0 -> done pulse next cycle, enb never asserted, m_valid never asserted.
REQ-041 Start while busy: second start with base_addr=50 during STREAM -> ignored, first transfer completes unchanged, single done pulse.
REQ-042 Reset mid-op: rst asserted during STREAM of row 1 of 3 -> all outputs 0 immediately (asynchronously), no done; new start after release streams correctly from its own base_addr.

Source files
------------

// File: rtl/bram_row_streamer.sv
// rtl/bram_row_streamer.sv - streams BRAM rows out one column per beat
//
// Purpose: reads num_rows consecutive rows from a BRAM read port starting at
// base_addr (wrapping modulo the BRAM depth). Each row is streamed out as
// NUMBER_OF_COLUMNS column beats with a valid/ready handshake.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   start                 begin a transfer (sampled only in IDLE)
//   base_addr, num_rows   transfer parameters, latched with start
//   busy, done            status: busy outside IDLE, done pulses once at completion
//   enb, addrb, doutb     BRAM read port (data valid one cycle after enb)
//   m_valid, m_ready      column beat handshake
//   m_data, m_col, m_last column value, its index, final-beat marker
module bram_row_streamer #(
  parameter int NUMBER_OF_COLUMNS = 8,
  parameter int COLUMN_WIDTH      = 16,
  parameter int DEPTH             = 128,
  localparam int ADDR_WIDTH       = $clog2(DEPTH),
  localparam int COL_IDX_WIDTH    = (NUMBER_OF_COLUMNS > 1) ? $clog2(NUMBER_OF_COLUMNS) : 1,
  localparam int DATA_WIDTH       = NUMBER_OF_COLUMNS * COLUMN_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic [ADDR_WIDTH:0]      num_rows,
  output logic                     busy,
  output logic                     done,
  output logic                     enb,
  output logic [ADDR_WIDTH-1:0]    addrb,
  input  logic [DATA_WIDTH-1:0]    doutb,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [COLUMN_WIDTH-1:0]  m_data,
  output logic [COL_IDX_WIDTH-1:0] m_col,
  output logic                     m_last
);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, STREAM, DONE} state_t;

  state_t                   state, state_next;
  logic [ADDR_WIDTH-1:0]    base_q;
  logic [ADDR_WIDTH:0]      num_q;
  logic [ADDR_WIDTH:0]      row_count;
  logic [COL_IDX_WIDTH-1:0] col_idx;
  logic [DATA_WIDTH-1:0]    row_q;
  logic [ADDR_WIDTH-1:0]    addr_q;

  logic                     last_col;
  logic                     last_row;
  logic [ADDR_WIDTH:0]      row_next;
  logic                     beat;

  assign last_col = (col_idx == COL_IDX_WIDTH'(NUMBER_OF_COLUMNS - 1));
  assign last_row = (row_count == num_q - 1'b1);
  // row_count never exceeds num_rows-1, so the increment cannot overflow.
  assign row_next = row_count + 1'b1;
  assign beat     = (state == STREAM) && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (num_rows != '0) ? READ : DONE;
        end
      end
      READ:    state_next = CAPTURE;
      CAPTURE: state_next = STREAM;
      STREAM: begin
        if (m_ready && last_col) begin
          state_next = (row_next < num_q) ? READ : DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers. The read address is computed when entering READ so
  // that addrb is a clean register output and simply holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q    <= '0;
      num_q     <= '0;
      row_count <= '0;
      col_idx   <= '0;
      row_q     <= '0;
      addr_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (num_rows != '0)) begin
            base_q    <= base_addr;
            num_q     <= num_rows;
            row_count <= '0;
            addr_q    <= base_addr;
          end
        end
        CAPTURE: begin
          row_q   <= doutb;
          col_idx <= '0;
        end
        STREAM: begin
          if (beat) begin
            if (!last_col) begin
              col_idx <= col_idx + 1'b1;
            end else if (row_next < num_q) begin
              row_count <= row_next;
              addr_q    <= base_q + row_next[ADDR_WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Column mux: column 0 occupies the least significant bits of the row.
  always_comb begin
    m_data = '0;
    for (int c = 0; c < NUMBER_OF_COLUMNS; c++) begin
      if (col_idx == COL_IDX_WIDTH'(c)) begin
        m_data = row_q[c*COLUMN_WIDTH +: COLUMN_WIDTH];
      end
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign enb     = (state == READ);
  assign addrb   = addr_q;
  assign m_valid = (state == STREAM);
  assign m_col   = col_idx;
  assign m_last  = (state == STREAM) && last_col && last_row;

endmodule
